// File: rtl/ram_bridge_pkg.sv
// Shared types and constants for the ram_bridge SRAM cycle generator.
package ram_bridge_pkg;

    // Width of the access wait counter; covers WAIT_CYC up to 15.
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } bridge_state_t;

    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } bridge_dir_t;

endpackage

// File: rtl/ram_bridge_wait_counter.sv
// Loadable down-counter that times the strobe-low part of an SRAM access.
// zero is asserted whenever the count has reached 0.
module ram_bridge_wait_counter
    import ram_bridge_pkg::*;
(
    input  logic              clock,
    input  logic              n_reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [WAIT_W-1:0] count;

    // Load takes priority over decrement; the count never wraps below 0.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ram_bridge.sv
// ram_bridge: turns the sequencer's single-cycle RAM strobes into a timed
// asynchronous SRAM cycle (setup, WAIT_CYC access cycles, hold).
// Optional write protection is compiled in with `define RAM_BRIDGE_PROT_EN.
//
// Handshake: a request is a clock edge with RAM_NCE=0 and either RAM_NWE=0
// (write, takes precedence) or RAM_NOE=0 (read) while busy=0; any request
// edge seen while busy=1 is dropped. Read data is valid for exactly the one
// cycle in which rdata_valid=1 and stays in rdata until the next read.
module ram_bridge
    import ram_bridge_pkg::*;
#(
    parameter int WORD_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int WAIT_CYC = 2,
    parameter int PROT_TOP = 7
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              RAM_NCE,
    input  logic              RAM_NOE,
    input  logic              RAM_NWE,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [WORD_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [WORD_W-1:0] sram_dq_in,
    output logic              sram_nce,
    output logic              sram_noe,
    output logic              sram_nwe,
    output logic              prot_err,
    output logic [1:0]        dbg_state
);

    bridge_state_t state, state_next;
    bridge_dir_t   dir, dir_next;
    logic          blocked, blocked_next;

    logic [WORD_W-1:0] rdata_next;
    logic              rdata_valid_next, busy_next;
    logic [ADDR_W-1:0] sram_addr_next;
    logic [WORD_W-1:0] sram_dq_out_next;
    logic              sram_dq_oe_next, sram_nce_next, sram_noe_next, sram_nwe_next;
    logic              prot_err_next;

    logic cnt_load, cnt_dec, cnt_zero;
    logic req_write, req_read, addr_protected;

    assign req_write = !RAM_NCE && !RAM_NWE;
    assign req_read  = !RAM_NCE && RAM_NWE && !RAM_NOE;

`ifdef RAM_BRIDGE_PROT_EN
    assign addr_protected = (int'(addr) <= PROT_TOP);
`else
    // PROT_TOP only matters when protection is compiled in.
    logic unused_prot_top;
    assign unused_prot_top = (PROT_TOP != 0);
    assign addr_protected  = 1'b0;
`endif

    ram_bridge_wait_counter u_wait_counter (
        .clock    (clock),
        .n_reset  (n_reset),
        .load     (cnt_load),
        .load_val (WAIT_W'(WAIT_CYC - 1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_next       = state;
        dir_next         = dir;
        blocked_next     = blocked;
        rdata_next       = rdata;
        rdata_valid_next = 1'b0;
        busy_next        = busy;
        sram_addr_next   = sram_addr;
        sram_dq_out_next = sram_dq_out;
        sram_dq_oe_next  = sram_dq_oe;
        sram_nce_next    = sram_nce;
        sram_noe_next    = sram_noe;
        sram_nwe_next    = sram_nwe;
        prot_err_next    = prot_err;
        cnt_load         = 1'b0;
        cnt_dec          = 1'b0;
        case (state)
            IDLE: begin
                if (req_write || req_read) begin
                    state_next     = SETUP;
                    busy_next      = 1'b1;
                    sram_nce_next  = 1'b0;
                    sram_addr_next = addr;
                    if (req_write) begin
                        dir_next         = DIR_WRITE;
                        blocked_next     = addr_protected;
                        sram_dq_out_next = wdata;
                        sram_dq_oe_next  = !addr_protected;
                    end else begin
                        dir_next     = DIR_READ;
                        blocked_next = 1'b0;
                    end
                end
            end
            SETUP: begin
                state_next = ACCESS;
                cnt_load   = 1'b1;
                if (dir == DIR_READ) begin
                    sram_noe_next = 1'b0;
                end else begin
                    sram_nwe_next = blocked;
                end
            end
            ACCESS: begin
                if (cnt_zero) begin
                    state_next    = HOLD;
                    sram_noe_next = 1'b1;
                    sram_nwe_next = 1'b1;
                    if (dir == DIR_READ) begin
                        rdata_next       = sram_dq_in;
                        rdata_valid_next = 1'b1;
                    end else begin
                        prot_err_next = prot_err || blocked;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            HOLD: begin
                state_next      = IDLE;
                busy_next       = 1'b0;
                sram_nce_next   = 1'b1;
                sram_dq_oe_next = 1'b0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any cycle with strobes high.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            dir         <= DIR_READ;
            blocked     <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            busy        <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_nce    <= 1'b1;
            sram_noe    <= 1'b1;
            sram_nwe    <= 1'b1;
            prot_err    <= 1'b0;
        end else begin
            state       <= state_next;
            dir         <= dir_next;
            blocked     <= blocked_next;
            rdata       <= rdata_next;
            rdata_valid <= rdata_valid_next;
            busy        <= busy_next;
            sram_addr   <= sram_addr_next;
            sram_dq_out <= sram_dq_out_next;
            sram_dq_oe  <= sram_dq_oe_next;
            sram_nce    <= sram_nce_next;
            sram_noe    <= sram_noe_next;
            sram_nwe    <= sram_nwe_next;
            prot_err    <= prot_err_next;
        end
    end

    assign dbg_state = state;

endmodule

// File: doc/ram_bridge.md
Name: ram_bridge

Overview:
- Sits directly downstream of the processor sequencer.
- Converts the sequencer's single-cycle active-low RAM strobes (RAM_NCE/RAM_NOE/RAM_NWE), the MAR address and the system-bus word into a timed external asynchronous-SRAM cycle: setup, WAIT_CYC access cycles, then hold.
- Returns read data with a valid pulse, and asserts busy so a wait-state-aware sequencer can stall.

Parameters:
- WORD_W, 8, data word width.
- ADDR_W, 5, address width (WORD_W minus 3-bit opcode).
- WAIT_CYC, 2, number of access cycles with strobe low; legal range 1..15.
- PROT_TOP, 7, highest write-protected address (used only with RAM_BRIDGE_PROT_EN).

Ports:
- clock  in  1  system clock, all state on rising edge
- n_reset  in  1  asynchronous active-low reset
- RAM_NCE  in  1  chip enable from sequencer, active low
- RAM_NOE  in  1  output enable from sequencer, active low
- RAM_NWE  in  1  write enable from sequencer, active low
- addr  in  ADDR_W  address from MAR
- wdata  in  WORD_W  write data from system bus
- rdata  out  WORD_W  registered read data
- rdata_valid  out  1  one-cycle pulse, rdata updated
- busy  out  1  transaction in progress, new requests ignored
- sram_addr  out  ADDR_W  external address
- sram_dq_out  out  WORD_W  external write data
- sram_dq_oe  out  1  drive enable for external data pins
- sram_dq_in  in  WORD_W  external read data
- sram_nce, sram_noe, sram_nwe  out  1 each  external strobes, active low
- prot_err  out  1  sticky write-protect violation (RAM_BRIDGE_PROT_EN only; otherwise tied 0)

Behaviour:
- Reset, asynchronous:
  - state=IDLE.
  - rdata=0, rdata_valid=0, busy=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0.
  - sram_nce=sram_noe=sram_nwe=1, prot_err=0.
- Reset mid-transaction aborts immediately; strobes deassert in the same instant, no data is captured.
- All outputs are registered.
- Request detection:
  - A request is accepted only in IDLE, on a clock edge with RAM_NCE=0.
  - RAM_NWE=0 means write (write wins if RAM_NOE=0 too); else RAM_NOE=0 means read; else no request (NCE-only is ignored).
  - addr, wdata and the direction are latched at acceptance.
  - Request edges seen while busy=1 are ignored, with no queueing.
- FSM, all cycles counted from acceptance edge T:
  - IDLE → SETUP (T+1): busy=1, sram_nce=0, sram_addr valid, strobes high. Write: sram_dq_oe=1, sram_dq_out=latched wdata.
  - SETUP → ACCESS (T+2 .. T+1+WAIT_CYC): sram_noe=0 (read) or sram_nwe=0 (write). A 4-bit counter runs from WAIT_CYC-1 down to 0.
  - ACCESS → HOLD when counter=0. On that transition edge a read captures sram_dq_in into rdata.
  - HOLD (T+2+WAIT_CYC): strobes high, sram_nce=0; write keeps sram_dq_oe=1 with data held; read pulses rdata_valid=1.
  - HOLD → IDLE (T+3+WAIT_CYC): busy=0, sram_nce=1, sram_dq_oe=0; a new request may be accepted on this edge.
- Latency: WAIT_CYC=2 gives rdata_valid at T+4 and busy low at T+5.
- rdata holds its value until the next completed read; writes never alter it.
- sram_addr and sram_dq_out hold their last values in IDLE.

Optional Feature:
- Macro: RAM_BRIDGE_PROT_EN.
- Defined:
  - A write with latched addr ≤ PROT_TOP still runs the full FSM timing, but sram_nwe stays 1 and sram_dq_oe stays 0 (no external write).
  - prot_err is set in HOLD and stays set until reset.
  - Reads are unaffected.
- Undefined: no protection logic; prot_err is constant 0.

Decomposition:
- Shared package ram_bridge_pkg:
  - typedef enum {IDLE, SETUP, ACCESS, HOLD} bridge_state_t.
  - typedef enum {DIR_READ, DIR_WRITE} bridge_dir_t.
  - WAIT_W=4 constant.
- One natural sub-module: wait_counter (loadable 4-bit down-counter with zero flag), instantiated once.

Test Plan:
- Read, WAIT_CYC=2, addr=5'h12, sram_dq_in=8'hA5 → sram_noe low exactly at T+2..T+3; rdata=8'hA5 with rdata_valid=1 at T+4; busy low at T+5.
- Write addr=5'h1F, wdata=8'h3C → sram_nwe low T+2..T+3; sram_dq_oe high T+1..T+4 with sram_dq_out=8'h3C; rdata unchanged.
- Both strobes low, addr=5'h10 → treated as write; sram_noe never low.
- Second RAM_NCE=0 at T+2 (busy) with addr=5'h01 → ignored; sram_addr stays 5'h12. Re-request at T+5 is accepted.
- n_reset low during ACCESS → all strobes 1, busy=0, rdata=0 immediately; FSM in IDLE after release.
- RAM_BRIDGE_PROT_EN, PROT_TOP=7: write addr=5'h03 → sram_nwe stays 1 and prot_err=1 from T+4. Write addr=5'h08 → normal write, prot_err stays 1.
